dco_tdc_model: RTL and testbench

- Synthesizable, clk-synchronous behavioural model of the ADPLL analog front end: a digitally controlled oscillator (DCO) plus a time-to-digital converter (TDC).
- Converts the DCO capacitor-bank codes into an oscillator period in femtoseconds.
- Computes the DCO-to-reference frequency ratio with a sequential divider.
- Accumulates DCO phase once per reference clock, giving the integer ripple count and the fractional phase that the digital loop consumes.

---
 rtl/dco_tdc_pkg.sv | 69 ++++++
 rtl/dco_tdc_model_if.sv | 51 +++++
 rtl/dco_tdc_model_seq_divider.sv | 91 +++++++++
 rtl/dco_tdc_model.sv | 129 ++++++++++++
 tb/tb_dco_tdc_model.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/dco_tdc_pkg.sv
// Shared constants, bank-code types and helpers for the DCO/TDC behavioural model.
package dco_tdc_pkg;

  localparam int unsigned L_W        = 5;
  localparam int unsigned MS_W       = 16;
  localparam int unsigned POP_W      = 5;
  localparam int unsigned FCW_W      = 23;
  localparam int unsigned FRAC_W     = 16;
  localparam int unsigned INT_W      = FCW_W - FRAC_W;
  localparam int unsigned DIV_CYCLES = 48;
  localparam int unsigned DIVIDEND_W = 48;
  localparam int unsigned DIVISOR_W  = 32;
  localparam int unsigned PERIOD_W   = 32;
  localparam int unsigned UNITS_S_W  = 9;
  localparam int unsigned CTR_W      = 3;

  typedef struct packed {
    logic [L_W-1:0] rall;
    logic [L_W-1:0] row;
    logic [L_W-1:0] col;
  } bank_l_t;

  typedef struct packed {
    logic [MS_W-1:0] rall;
    logic [MS_W-1:0] row;
    logic [MS_W-1:0] col;
  } bank_ms_t;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_RUN  = 1'b1
  } div_state_e;

  function automatic logic [POP_W-1:0] popcount(input logic [MS_W-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(MS_W); i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

  // Full rows contribute a whole column width; a partial row adds its enabled columns.
  function automatic logic [PERIOD_W-1:0] units_l(input bank_l_t b);
    return PERIOD_W'(L_W) * PERIOD_W'(popcount(MS_W'(b.rall)))
         + ((|b.row) ? PERIOD_W'(popcount(MS_W'(b.col))) : '0);
  endfunction

  function automatic logic [PERIOD_W-1:0] units_ms(input bank_ms_t b);
    return PERIOD_W'(MS_W) * PERIOD_W'(popcount(b.rall))
         + ((|b.row) ? PERIOD_W'(popcount(b.col)) : '0);
  endfunction

  // Keeps the top min(10+ctr,16) phase bits.
  function automatic logic [FRAC_W-1:0] phase_mask(input logic [CTR_W-1:0] ctr);
    logic [FRAC_W-1:0] m;
    case (ctr)
      3'd0:    m = 16'hFFC0;
      3'd1:    m = 16'hFFE0;
      3'd2:    m = 16'hFFF0;
      3'd3:    m = 16'hFFF8;
      3'd4:    m = 16'hFFFC;
      3'd5:    m = 16'hFFFE;
      default: m = 16'hFFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dco_tdc_model_if.sv
// DCO control / TDC observation bundle. DCO_TDC_DBG_EN adds the small-bank debug sum.
interface dco_tdc_model_if;
  import dco_tdc_pkg::*;

  logic                 dco_pd;
  logic [1:0]           dco_osc_gain;
  logic [L_W-1:0]       dco_c_l_rall;
  logic [L_W-1:0]       dco_c_l_row;
  logic [L_W-1:0]       dco_c_l_col;
  logic [MS_W-1:0]      dco_c_m_rall;
  logic [MS_W-1:0]      dco_c_m_row;
  logic [MS_W-1:0]      dco_c_m_col;
  logic [MS_W-1:0]      dco_c_s_rall;
  logic [MS_W-1:0]      dco_c_s_row;
  logic [MS_W-1:0]      dco_c_s_col;
  logic                 dco_ckv;
  logic [PERIOD_W-1:0]  dco_period_fs;
  logic                 tdc_pd;
  logic                 tdc_pd_inj;
  logic [CTR_W-1:0]     tdc_ctr_freq;
  logic [INT_W-1:0]     tdc_ripple_count;
  logic [FRAC_W-1:0]    tdc_phase;
`ifdef DCO_TDC_DBG_EN
  logic [UNITS_S_W-1:0] dbg_c_s_units;
`endif

  modport master (
    output dco_pd, dco_osc_gain,
    output dco_c_l_rall, dco_c_l_row, dco_c_l_col,
    output dco_c_m_rall, dco_c_m_row, dco_c_m_col,
    output dco_c_s_rall, dco_c_s_row, dco_c_s_col,
    output tdc_pd, tdc_pd_inj, tdc_ctr_freq,
    input  dco_ckv, dco_period_fs, tdc_ripple_count, tdc_phase
`ifdef DCO_TDC_DBG_EN
    , input dbg_c_s_units
`endif
  );

  modport slave (
    input  dco_pd, dco_osc_gain,
    input  dco_c_l_rall, dco_c_l_row, dco_c_l_col,
    input  dco_c_m_rall, dco_c_m_row, dco_c_m_col,
    input  dco_c_s_rall, dco_c_s_row, dco_c_s_col,
    input  tdc_pd, tdc_pd_inj, tdc_ctr_freq,
    output dco_ckv, dco_period_fs, tdc_ripple_count, tdc_phase
`ifdef DCO_TDC_DBG_EN
    , output dbg_c_s_units
`endif
  );

endinterface

// File: rtl/dco_tdc_model_seq_divider.sv
// Restoring divider, one quotient bit per cycle, saturating quotient; clear aborts to idle.
module seq_divider
  import dco_tdc_pkg::*;
#(
  parameter int unsigned DVD_W  = DIVIDEND_W,
  parameter int unsigned DVS_W  = DIVISOR_W,
  parameter int unsigned QUO_W  = FCW_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [QUO_W-1:0] quotient
);

  localparam int unsigned CNT_W = $clog2(DVD_W);

  div_state_e       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [DVD_W-1:0] num_d, num_q;
  logic [DVS_W:0]   rem_d, rem_q;
  logic [DVS_W-1:0] dvs_d, dvs_q;
  logic [QUO_W-1:0] quo_d, quo_q;
  logic             done_d, done_q;
  logic [DVS_W:0]   rem_sh_c;
  logic             ge_c;
  logic [DVD_W-1:0] q_full_c;

  // Dividend bits shift out the top while quotient bits shift in at the bottom.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    num_d    = num_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    quo_d    = quo_q;
    done_d   = 1'b0;
    rem_sh_c = {rem_q[DVS_W-1:0], num_q[DVD_W-1]};
    ge_c     = (rem_sh_c >= {1'b0, dvs_q});
    q_full_c = {num_q[DVD_W-2:0], ge_c};

    if (clear) begin
      state_d = DIV_IDLE;
    end else if (start) begin
      state_d = DIV_RUN;
      cnt_d   = CNT_W'(DVD_W - 1);
      num_d   = dividend;
      rem_d   = '0;
      dvs_d   = divisor;
    end else if (state_q == DIV_RUN) begin
      rem_d = ge_c ? (rem_sh_c - {1'b0, dvs_q}) : rem_sh_c;
      num_d = q_full_c;
      if (cnt_q == '0) begin
        state_d = DIV_IDLE;
        done_d  = 1'b1;
        quo_d   = (|q_full_c[DVD_W-1:QUO_W]) ? '1 : q_full_c[QUO_W-1:0];
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == DIV_RUN);
  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/dco_tdc_model.sv
// DCO period from bank codes, DCO/ref ratio via seq_divider, and TDC phase accumulator.
// Optional DCO_TDC_DBG_EN exposes the registered small-bank unit sum.
module dco_tdc_model
  import dco_tdc_pkg::*;
#(
  parameter int unsigned REF_PERIOD_FS  = 25000000,
  parameter int unsigned BASE_PERIOD_FS = 416667,
  parameter int unsigned L_STEP_FS      = 2000,
  parameter int unsigned M_STEP_FS      = 100,
  parameter int unsigned S_STEP_FS      = 5
) (
  input logic             clk,
  input logic             rst_n,
  dco_tdc_model_if.slave  bus
);

  localparam logic [DIVIDEND_W-1:0] DIVIDEND = DIVIDEND_W'(REF_PERIOD_FS) << FRAC_W;

  bank_l_t             bank_l_c;
  bank_ms_t            bank_m_c, bank_s_c;
  logic [PERIOD_W-1:0] units_l_c, units_m_c, units_s_c;
  logic [PERIOD_W-1:0] period_d, period_q;
  logic                start_d, start_q;
  logic                change_c;
  logic [FCW_W-1:0]    fcw_d, fcw_q;
  logic [FCW_W-1:0]    acc_d, acc_q;
  logic                ckv_d, ckv_q;
  logic [INT_W-1:0]    ripple_d, ripple_q;
  logic [FRAC_W-1:0]   phase_d, phase_q;
  logic                div_start_c, div_clear_c, div_busy, div_done;
  logic [FCW_W-1:0]    div_quot;

  assign bank_l_c = '{rall: bus.dco_c_l_rall, row: bus.dco_c_l_row, col: bus.dco_c_l_col};
  assign bank_m_c = '{rall: bus.dco_c_m_rall, row: bus.dco_c_m_row, col: bus.dco_c_m_col};
  assign bank_s_c = '{rall: bus.dco_c_s_rall, row: bus.dco_c_s_row, col: bus.dco_c_s_col};

  // Oscillator period; a stopped oscillator reports period 0.
  always_comb begin
    units_l_c = units_l(bank_l_c);
    units_m_c = units_ms(bank_m_c);
    units_s_c = units_ms(bank_s_c);
    period_d  = '0;
    if (!bus.dco_pd && (bus.dco_osc_gain != 2'd0)) begin
      period_d = PERIOD_W'(BASE_PERIOD_FS)
               + PERIOD_W'(L_STEP_FS) * units_l_c
               + PERIOD_W'(M_STEP_FS) * units_m_c
               + PERIOD_W'(S_STEP_FS) * units_s_c;
    end
    change_c = (period_d != period_q);
    start_d  = change_c;
  end

  assign div_start_c = start_q && (period_q != '0);
  assign div_clear_c = (period_q == '0);

  seq_divider #(
    .DVD_W (DIVIDEND_W),
    .DVS_W (DIVISOR_W),
    .QUO_W (FCW_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start_c),
    .clear    (div_clear_c),
    .dividend (DIVIDEND),
    .divisor  (period_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot)
  );

  // A result is only taken if no newer period is pending or arriving this cycle.
  always_comb begin
    fcw_d = fcw_q;
    if (period_q == '0) begin
      fcw_d = '0;
    end else if (div_done && !div_busy && !start_q && !change_c) begin
      fcw_d = div_quot;
    end
    acc_d    = bus.tdc_pd ? '0 : (acc_q + fcw_q);
    ripple_d = acc_d[FCW_W-1:FRAC_W];
    phase_d  = bus.tdc_pd_inj ? '0 : (acc_d[FRAC_W-1:0] & phase_mask(bus.tdc_ctr_freq));
    ckv_d    = acc_d[FRAC_W-1] && (period_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_q <= '0;
      start_q  <= 1'b0;
      fcw_q    <= '0;
      acc_q    <= '0;
      ckv_q    <= 1'b0;
      ripple_q <= '0;
      phase_q  <= '0;
    end else begin
      period_q <= period_d;
      start_q  <= start_d;
      fcw_q    <= fcw_d;
      acc_q    <= acc_d;
      ckv_q    <= ckv_d;
      ripple_q <= ripple_d;
      phase_q  <= phase_d;
    end
  end

  assign bus.dco_period_fs    = period_q;
  assign bus.dco_ckv          = ckv_q;
  assign bus.tdc_ripple_count = ripple_q;
  assign bus.tdc_phase        = phase_q;

`ifdef DCO_TDC_DBG_EN
  logic [UNITS_S_W-1:0] units_s_d, units_s_q;

  always_comb begin
    units_s_d = UNITS_S_W'(units_s_c);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      units_s_q <= '0;
    end else begin
      units_s_q <= units_s_d;
    end
  end

  assign bus.dbg_c_s_units = units_s_q;
`endif

endmodule

// File: tb/tb_dco_tdc_model.sv
// Randomized bench for dco_tdc_model against a cycle-level arithmetic reference model.
module tb_dco_tdc_model;

  localparam longint unsigned REF_FS  = 25000000;
  localparam longint unsigned BASE_FS = 416667;
  localparam longint unsigned L_FS    = 2000;
  localparam longint unsigned M_FS    = 100;
  localparam longint unsigned S_FS    = 5;
  localparam int              FCW_LAT = 50;  // change -> restart (+1), 48 bits, load (+1)

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dco_tdc_model_if bus();

  dco_tdc_model #(
    .REF_PERIOD_FS  (25000000),
    .BASE_PERIOD_FS (416667),
    .L_STEP_FS      (2000),
    .M_STEP_FS      (100),
    .S_STEP_FS      (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  longint unsigned m_period, m_fcw, m_acc, m_us;
  int              m_cnt;
  longint unsigned e_ripple, e_phase, e_ckv;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint unsigned units(input int w, input logic [15:0] rall,
                                            input logic [15:0] row, input logic [15:0] col);
    return longint'(w * $countones(rall)) + ((row != 16'd0) ? longint'($countones(col)) : 0);
  endfunction

  function automatic longint unsigned quot(input longint unsigned p);
    longint unsigned q;
    q = (REF_FS << 16) / p;
    return (q > 64'd8388607) ? 64'd8388607 : q;
  endfunction

  // Advance the reference by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    longint unsigned p_new, f, a, ph;
    bit changed;
    int n;
    if (!rst_n) begin
      m_period = 0; m_fcw = 0; m_acc = 0; m_us = 0; m_cnt = 1000;
      e_ripple = 0; e_phase = 0; e_ckv = 0;
      return;
    end
    m_us = units(16, bus.dco_c_s_rall, bus.dco_c_s_row, bus.dco_c_s_col);
    if (bus.dco_pd || bus.dco_osc_gain == 2'd0) p_new = 0;
    else p_new = BASE_FS
               + L_FS * units(5, 16'(bus.dco_c_l_rall), 16'(bus.dco_c_l_row), 16'(bus.dco_c_l_col))
               + M_FS * units(16, bus.dco_c_m_rall, bus.dco_c_m_row, bus.dco_c_m_col)
               + S_FS * m_us;
    changed = (p_new != m_period);
    if (m_period == 0) f = 0;
    else if (!changed && m_cnt == FCW_LAT - 1) f = quot(m_period);
    else f = m_fcw;
    a = bus.tdc_pd ? 0 : ((m_acc + m_fcw) % (64'd1 << 23));
    m_cnt = changed ? 0 : ((m_cnt < 1000) ? m_cnt + 1 : 1000);
    m_period = p_new; m_fcw = f; m_acc = a;
    n = 10 + int'(bus.tdc_ctr_freq);
    if (n > 16) n = 16;
    ph = a % 65536;
    ph = (ph >> (16 - n)) << (16 - n);
    if (bus.tdc_pd_inj) ph = 0;
    e_ripple = (a >> 16) % 128;
    e_phase  = ph;
    e_ckv    = (((a >> 15) % 2) == 1 && p_new != 0) ? 1 : 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("period", 64'(bus.dco_period_fs), 64'(m_period));
    chk("ripple", 64'(bus.tdc_ripple_count), 64'(e_ripple));
    chk("phase", 64'(bus.tdc_phase), 64'(e_phase));
    chk("ckv", 64'(bus.dco_ckv), 64'(e_ckv));
`ifdef DCO_TDC_DBG_EN
    chk("dbg_units", 64'(bus.dbg_c_s_units), 64'(m_us));
`endif
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic zero_codes();
    bus.dco_c_l_rall = '0; bus.dco_c_l_row = '0; bus.dco_c_l_col = '0;
    bus.dco_c_m_rall = '0; bus.dco_c_m_row = '0; bus.dco_c_m_col = '0;
    bus.dco_c_s_rall = '0; bus.dco_c_s_row = '0; bus.dco_c_s_col = '0;
  endtask

  task automatic rand_codes();
    bus.dco_c_l_rall = 5'($urandom); bus.dco_c_l_row = 5'($urandom); bus.dco_c_l_col = 5'($urandom);
    bus.dco_c_m_rall = 16'($urandom); bus.dco_c_m_row = 16'($urandom); bus.dco_c_m_col = 16'($urandom);
    bus.dco_c_s_rall = 16'($urandom); bus.dco_c_s_row = 16'($urandom); bus.dco_c_s_col = 16'($urandom);
  endtask

  initial begin
    logic [6:0] r0;
    logic [6:0] delta;
    zero_codes();
    bus.dco_pd = 1'b0; bus.dco_osc_gain = 2'd1;
    bus.tdc_pd = 1'b0; bus.tdc_pd_inj = 1'b0; bus.tdc_ctr_freq = 3'd7;
    rst_n = 1'b0;
    hold(3);

    rst_n = 1'b1;
    cyc();
    chk("period_after_reset", 64'(bus.dco_period_fs), 64'd416667);
    hold(60);
    r0 = bus.tdc_ripple_count;
    cyc();
    delta = bus.tdc_ripple_count - r0;
    chk("ripple_step_59_60", 64'((delta == 7'd59) || (delta == 7'd60)), 64'd1);

    bus.dco_c_s_rall = 16'h0001;
    cyc();
    chk("period_s_unit", 64'(bus.dco_period_fs), 64'd416747);
    hold(60);

    bus.dco_c_l_rall = 5'h1F; bus.dco_c_l_row = 5'h1F; bus.dco_c_l_col = 5'h1F;
    bus.dco_c_s_rall = 16'h0000;
    cyc();
    chk("period_l_full", 64'(bus.dco_period_fs), 64'd476667);
    hold(60);

    bus.dco_pd = 1'b1;  hold(10);
    bus.dco_pd = 1'b0;  hold(60);
    bus.tdc_ctr_freq = 3'd0; hold(5);
    bus.tdc_pd_inj = 1'b1;   hold(5);
    bus.tdc_pd_inj = 1'b0; bus.tdc_pd = 1'b1; hold(5);
    bus.tdc_pd = 1'b0; bus.tdc_ctr_freq = 3'd7;

    // Retune in the middle of a division; the stale result must never appear.
    rand_codes(); hold(20);
    rand_codes(); hold(60);
    bus.dco_osc_gain = 2'd0; hold(5);
    bus.dco_osc_gain = 2'd3; hold(55);

    for (int s = 0; s < 60; s++) begin
      rst_n = ($urandom_range(0, 29) != 0);
      if ($urandom_range(0, 2) != 0) rand_codes();
      bus.dco_pd       = ($urandom_range(0, 7) == 0);
      bus.dco_osc_gain = ($urandom_range(0, 9) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      bus.tdc_pd       = ($urandom_range(0, 7) == 0);
      bus.tdc_pd_inj   = ($urandom_range(0, 3) == 0);
      bus.tdc_ctr_freq = 3'($urandom);
      hold($urandom_range(1, 70));
    end
    rst_n = 1'b1; bus.dco_pd = 1'b0; bus.dco_osc_gain = 2'd1; bus.tdc_pd = 1'b0;
    hold(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
